// File: rtl/hamming_decoder_pipe.sv
// Two-stage streaming Hamming (7,4) decoder with single-error correction.
// Stage 1 captures the codeword and its syndrome. Stage 2 applies the correction
// and holds the decoded result, which drives the outputs directly. Both stages
// support full backpressure. A saturating counter counts the corrected words
// that have entered stage 2.
module hamming_decoder_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic [2:0]       syndrome,
  output logic             corrected,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  // Stage 1 registers
  logic             r_s1_valid;
  logic [6:0]       r_s1_code;
  logic [2:0]       r_s1_synd;

  // Stage 2 registers (these drive the outputs)
  logic             r_out_valid;
  logic [3:0]       r_data_out;
  logic [2:0]       r_syndrome;
  logic             r_corrected;
  logic [CNT_W-1:0] r_err_count;

  // Combinational signals
  logic       w_s2_adv;
  logic       w_s1_adv;
  logic [2:0] w_in_synd;
  logic [6:0] w_flip_mask;
  logic [6:0] w_fix_code;
  logic       w_s1_corr;
  logic       w_cnt_inc;

  // Handshake: a stage advances when it is empty or the stage after it drains
  always_comb begin
    w_s2_adv = !r_out_valid || out_ready;
    w_s1_adv = !r_s1_valid || w_s2_adv;
    in_ready = w_s1_adv;
  end

  // Syndrome of the incoming codeword; bit i of the codeword is Hamming position i+1
  always_comb begin
    w_in_synd[0] = codeword[0] ^ codeword[2] ^ codeword[4] ^ codeword[6];
    w_in_synd[1] = codeword[1] ^ codeword[2] ^ codeword[5] ^ codeword[6];
    w_in_synd[2] = codeword[3] ^ codeword[4] ^ codeword[5] ^ codeword[6];
  end

  // Correction mask: a nonzero syndrome S selects codeword bit S-1 to invert
  always_comb begin
    w_flip_mask = '0;
    case (r_s1_synd)
      3'd1:    w_flip_mask = 7'b000_0001;
      3'd2:    w_flip_mask = 7'b000_0010;
      3'd3:    w_flip_mask = 7'b000_0100;
      3'd4:    w_flip_mask = 7'b000_1000;
      3'd5:    w_flip_mask = 7'b001_0000;
      3'd6:    w_flip_mask = 7'b010_0000;
      3'd7:    w_flip_mask = 7'b100_0000;
      default: w_flip_mask = '0;
    endcase
    w_fix_code = r_s1_code ^ w_flip_mask;
    w_s1_corr  = (r_s1_synd != 3'd0);
  end

  // The counter steps when a corrected word enters stage 2 and is not yet saturated
  always_comb begin
    w_cnt_inc = w_s2_adv && r_s1_valid && w_s1_corr && (r_err_count != '1);
  end

  // Stage 1: take a new codeword whenever the stage advances and input is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_synd  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_code <= codeword;
        r_s1_synd <= w_in_synd;
      end
    end
  end

  // Stage 2: latch the corrected data; it holds while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_syndrome  <= '0;
      r_corrected <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data_out  <= {w_fix_code[6], w_fix_code[5], w_fix_code[4], w_fix_code[2]};
        r_syndrome  <= r_s1_synd;
        r_corrected <= w_s1_corr;
      end
    end
  end

  // Saturating corrected-word counter; a clear overrides an increment in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (clr_count) begin
      r_err_count <= '0;
    end else if (w_cnt_inc) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign syndrome  = r_syndrome;
  assign corrected = r_corrected;
  assign err_count = r_err_count;

endmodule
